// File: rtl/dms_pfd_if.sv
// Port bundle of the sampled phase-frequency detector: async clock inputs,
// enable, and the up/down, phase-error, slip and lock results.
interface dms_pfd_if #(
  parameter int ERR_W  = 8,
  parameter int SLIP_W = 8
);
  logic                    en;
  logic                    refclk;
  logic                    finalclk;
  logic                    up;
  logic                    down;
  logic                    err_valid;
  logic signed [ERR_W-1:0] err;
  logic                    err_sat;
  logic                    cycle_slip;
  logic [SLIP_W-1:0]       slip_cnt;
  logic                    lock;

  modport master (
    output en, refclk, finalclk,
    input  up, down, err_valid, err, err_sat, cycle_slip, slip_cnt, lock
  );

  modport slave (
    input  en, refclk, finalclk,
    output up, down, err_valid, err, err_sat, cycle_slip, slip_cnt, lock
  );
endinterface

// File: rtl/dms_pfd_sampled.sv
// Fully synchronous PFD: oversamples refclk/finalclk, measures the edge spacing in
// clk cycles and reports signed phase error, cycle slips and phase lock.
module dms_pfd_sampled #(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8,
  parameter int DEADZONE    = 0,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_COUNT  = 16,
  parameter int SLIP_W      = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  dms_pfd_if.slave  bus
);
  localparam int CW = ERR_W - 1;
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0]    MAXC  = {CW{1'b1}};
  localparam logic [CW-1:0]    DZ    = CW'(DEADZONE);
  localparam logic [ERR_W-1:0] TOL   = ERR_W'(LOCK_TOL);
  localparam logic [LW-1:0]    LCNT  = LW'(LOCK_COUNT);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LEAD = 2'd1;
  localparam logic [1:0] ST_LAG  = 2'd2;

  logic [SYNC_STAGES-1:0] ref_sync_r, fb_sync_r;
  logic ref_hist_r, fb_hist_r, ref_rise_r, fb_rise_r;
  logic [1:0] state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s, cnt_inc_s, mag_s;
  logic ev_s, slip_s, neg_s, sat_s;
  logic [ERR_W-1:0] mag_ext_s, err_val_s, err_abs_s;
  logic err_valid_r, err_sat_r, cycle_slip_r, lock_r, in_tol_s;
  logic [ERR_W-1:0] err_r;
  logic [SLIP_W-1:0] slip_cnt_r;
  logic [LW-1:0] lock_cnt_r;

  // synchronise both async inputs and register a one-cycle rising-edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_sync_r <= {SYNC_STAGES{1'b0}};
      fb_sync_r  <= {SYNC_STAGES{1'b0}};
      ref_hist_r <= 1'b0;
      fb_hist_r  <= 1'b0;
      ref_rise_r <= 1'b0;
      fb_rise_r  <= 1'b0;
    end else begin
      ref_sync_r <= {ref_sync_r[SYNC_STAGES-2:0], bus.refclk};
      fb_sync_r  <= {fb_sync_r[SYNC_STAGES-2:0], bus.finalclk};
      ref_hist_r <= ref_sync_r[SYNC_STAGES-1];
      fb_hist_r  <= fb_sync_r[SYNC_STAGES-1];
      ref_rise_r <= ref_sync_r[SYNC_STAGES-1] & ~ref_hist_r;
      fb_rise_r  <= fb_sync_r[SYNC_STAGES-1] & ~fb_hist_r;
    end
  end

  assign cnt_inc_s = (cnt_r == MAXC) ? MAXC : cnt_r + CW'(1);

  // PFD next-state: a closing edge reports the cycles elapsed since the opening edge
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    ev_s        = 1'b0;
    slip_s      = 1'b0;
    neg_s       = 1'b0;
    mag_s       = {CW{1'b0}};
    if (!bus.en) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ref_rise_r && fb_rise_r) begin
            ev_s = 1'b1;
          end else if (ref_rise_r) begin
            state_nxt_s = ST_LEAD;
            cnt_nxt_s   = CW'(1);
          end else if (fb_rise_r) begin
            state_nxt_s = ST_LAG;
            cnt_nxt_s   = CW'(1);
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LEAD: begin
          if (fb_rise_r) begin
            ev_s        = 1'b1;
            mag_s       = cnt_r;
            state_nxt_s = ref_rise_r ? ST_LEAD : ST_IDLE;
            cnt_nxt_s   = ref_rise_r ? CW'(1) : {CW{1'b0}};
          end else begin
            slip_s    = ref_rise_r;
            cnt_nxt_s = cnt_inc_s;
          end
        end
        ST_LAG: begin
          neg_s = 1'b1;
          if (ref_rise_r) begin
            ev_s        = 1'b1;
            mag_s       = cnt_r;
            state_nxt_s = fb_rise_r ? ST_LAG : ST_IDLE;
            cnt_nxt_s   = fb_rise_r ? CW'(1) : {CW{1'b0}};
          end else begin
            slip_s    = fb_rise_r;
            cnt_nxt_s = cnt_inc_s;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  assign sat_s     = (mag_s == MAXC);
  assign mag_ext_s = (mag_s <= DZ) ? {ERR_W{1'b0}} : {1'b0, mag_s};
  assign err_val_s = neg_s ? -mag_ext_s : mag_ext_s;

  // FSM state, comparison results and saturating slip counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CW{1'b0}};
      err_valid_r  <= 1'b0;
      err_r        <= {ERR_W{1'b0}};
      err_sat_r    <= 1'b0;
      cycle_slip_r <= 1'b0;
      slip_cnt_r   <= {SLIP_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      err_valid_r  <= ev_s;
      err_r        <= ev_s ? err_val_s : {ERR_W{1'b0}};
      err_sat_r    <= ev_s & sat_s;
      cycle_slip_r <= slip_s;
      if (slip_s && (slip_cnt_r != {SLIP_W{1'b1}})) begin
        slip_cnt_r <= slip_cnt_r + SLIP_W'(1);
      end
    end
  end

  assign err_abs_s = err_r[ERR_W-1] ? -err_r : err_r;
  assign in_tol_s  = !err_sat_r && (err_abs_s <= TOL);

  // lock qualifies the results just published; any bad result drops it at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_r <= {LW{1'b0}};
      lock_r     <= 1'b0;
    end else if (!bus.en || cycle_slip_r || (err_valid_r && !in_tol_s)) begin
      lock_cnt_r <= {LW{1'b0}};
      lock_r     <= 1'b0;
    end else if (err_valid_r) begin
      if (lock_cnt_r >= LCNT - LW'(1)) begin
        lock_cnt_r <= LCNT;
        lock_r     <= 1'b1;
      end else begin
        lock_cnt_r <= lock_cnt_r + LW'(1);
      end
    end
  end

  assign bus.up         = (state_r == ST_LEAD);
  assign bus.down       = (state_r == ST_LAG);
  assign bus.err_valid  = err_valid_r;
  assign bus.err        = err_r;
  assign bus.err_sat    = err_sat_r;
  assign bus.cycle_slip = cycle_slip_r;
  assign bus.slip_cnt   = slip_cnt_r;
  assign bus.lock       = lock_r;
endmodule

// File: tb/tb_dms_pfd_sampled.sv
// Scoreboard bench for dms_pfd_sampled: expected phase errors and slip counts are
// queued as edges are driven and checked when the detector reports them.
module tb_dms_pfd_sampled;
  localparam int ERR_W  = 8;
  localparam int SLIP_W = 8;

  typedef struct { int err; int sat; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dms_pfd_if #(.ERR_W(ERR_W), .SLIP_W(SLIP_W)) pif ();
  dms_pfd_if #(.ERR_W(ERR_W), .SLIP_W(SLIP_W)) dif ();

  assign dif.en       = pif.en;
  assign dif.refclk   = pif.refclk;
  assign dif.finalclk = pif.finalclk;

  dms_pfd_sampled u_dut (.clk(clk), .rst_n(rst_n), .bus(pif));
  dms_pfd_sampled #(.DEADZONE(2)) u_dz (.clk(clk), .rst_n(rst_n), .bus(dif));

  exp_t exp_q[$];
  int   slip_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   up_total = 0;
  int   down_total = 0;
  int   slip_exp = 0;

  task automatic check(input string tag, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Output monitor: scoreboard pops plus a reference lock counter.
  task automatic monitor();
    int   lk_cnt = 0;
    int   lk = 0;
    bit   lk_pend = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (lk_pend) begin
        check("lock", int'(pif.lock), lk);
        lk_pend = 1'b0;
      end
      if (!rst_n || !pif.en) begin
        lk_cnt = 0;
        lk = 0;
      end
      up_total   += int'(pif.up);
      down_total += int'(pif.down);
      check("up_down_excl", int'(pif.up & pif.down), 0);
      if (pif.err_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_err_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("err", int'($signed(pif.err)), e.err);
          check("err_sat", int'(pif.err_sat), e.sat);
          check("dz_err_valid", int'(dif.err_valid), 1);
          check("dz_err", int'($signed(dif.err)), (iabs(e.err) <= 2) ? 0 : e.err);
          if (e.sat != 0 || iabs(e.err) > 2) begin
            lk_cnt = 0;
            lk = 0;
          end else begin
            lk_cnt++;
            if (lk_cnt >= 16) lk = 1;
          end
          lk_pend = 1'b1;
        end
      end
      if (pif.cycle_slip) begin
        if (slip_q.size() == 0) check("unexpected_slip", 1, 0);
        else check("slip_cnt", int'(pif.slip_cnt), slip_q.pop_front());
        lk_cnt = 0;
        lk = 0;
        lk_pend = 1'b1;
      end
    end
  endtask

  // One 40-cycle period; lead>0 means ref rises first. en_off/rst_at abort mid-period.
  task automatic run_period(input int lead, input bit do_ref, input bit do_fb,
                            input int en_off, input int rst_at);
    int r0, f0, u0, d0;
    bit clean;
    r0 = (lead >= 0) ? 0 : -lead;
    f0 = (lead >= 0) ? lead : 0;
    clean = do_ref && do_fb && en_off < 0 && rst_at < 0;
    if (clean) exp_q.push_back('{err: lead, sat: 0});
    u0 = up_total;
    d0 = down_total;
    pif.en = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #2;
      if (c == en_off) begin
        check("down_before_en_off", int'(pif.down), 1);
        pif.en = 1'b0;
      end
      if (c == en_off + 1 && en_off >= 0) begin
        check("down_after_en_off", int'(pif.down), 0);
        check("slip_hold_en_off", int'(pif.slip_cnt), slip_exp);
      end
      if (c == rst_at) begin
        check("up_before_rst", int'(pif.up), 1);
        rst_n = 1'b0;
        #1;
        check("rst_up", int'(pif.up), 0);
        check("rst_err_valid", int'(pif.err_valid), 0);
        check("rst_slip_cnt", int'(pif.slip_cnt), 0);
        slip_exp = 0;
      end
      pif.refclk   = do_ref && (c >= r0) && (c < r0 + 20);
      pif.finalclk = do_fb && (c >= f0) && (c < f0 + 20);
    end
    if (clean) begin
      check("up_cycles", up_total - u0, (lead > 0) ? lead : 0);
      check("down_cycles", down_total - d0, (lead < 0) ? -lead : 0);
    end
  endtask

  initial begin
    pif.en = 1'b1;
    pif.refclk = 1'b0;
    pif.finalclk = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check("rst_up0", int'(pif.up), 0);
    check("rst_down0", int'(pif.down), 0);
    check("rst_err_valid0", int'(pif.err_valid), 0);
    check("rst_err0", int'(pif.err), 0);
    check("rst_err_sat0", int'(pif.err_sat), 0);
    check("rst_cycle_slip0", int'(pif.cycle_slip), 0);
    check("rst_slip_cnt0", int'(pif.slip_cnt), 0);
    check("rst_lock0", int'(pif.lock), 0);

    for (int i = 0; i < 4; i++) run_period(5, 1'b1, 1'b1, -1, -1);
    for (int i = 0; i < 4; i++) run_period(-3, 1'b1, 1'b1, -1, -1);
    for (int i = 0; i < 2; i++) run_period(0, 1'b1, 1'b1, -1, -1);
    for (int i = 0; i < 2; i++) run_period(2, 1'b1, 1'b1, -1, -1);
    for (int i = 0; i < 12; i++) run_period(1, 1'b1, 1'b1, -1, -1);
    check("lock_acquired", int'(pif.lock), 1);
    run_period(10, 1'b1, 1'b1, -1, -1);
    check("lock_dropped", int'(pif.lock), 0);
    for (int i = 0; i < 16; i++) run_period(1, 1'b1, 1'b1, -1, -1);
    check("lock_reacquired", int'(pif.lock), 1);

    // feedback stalls: each further ref edge is a slip, then a late fb saturates
    run_period(0, 1'b1, 1'b0, -1, -1);
    for (int i = 0; i < 3; i++) begin
      slip_exp++;
      slip_q.push_back(slip_exp);
      run_period(0, 1'b1, 1'b0, -1, -1);
    end
    exp_q.push_back('{err: 127, sat: 1});
    run_period(0, 1'b0, 1'b1, -1, -1);
    check("lock_after_slip", int'(pif.lock), 0);
    check("slip_cnt_total", int'(pif.slip_cnt), 3);

    run_period(-8, 1'b1, 1'b1, 5, -1);
    check("slip_kept_en_off", int'(pif.slip_cnt), 3);
    run_period(5, 1'b1, 1'b1, -1, -1);
    run_period(8, 1'b1, 1'b1, -1, 5);
    run_period(-3, 1'b1, 1'b1, -1, -1);

    repeat (10) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("slip_q_drained", slip_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
